// File: rtl/memory_interface_unit.sv
// memory_interface_unit: bridges the CPU's MAR/MDR request pair onto a single-port RAM with an ack handshake.
// Latency: 3 cycles from the request cycle to mem_ready when ram_ack arrives in the first wait cycle.
// Backpressure: requests are only sampled in IDLE; anything presented while busy is dropped (no queue).
// Optional feature macro: MEM_IF_TIMEOUT_EN adds a 4-bit wait counter, the ERR state and a sticky mem_error.
// Ports: Clock/Reset (sync, active-low); MAR_addr/MDR_wdata/mem_read/mem_write from the CPU;
//   ram_addr/ram_wdata/ram_re/ram_we/ram_rdata/ram_ack to the RAM;
//   mem_rdata/mem_ready/mem_busy/mem_error back to the CPU.
module memory_interface_unit #(
  parameter int ADDR_WIDTH     = 9,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [ADDR_WIDTH-1:0] MAR_addr,
  input  logic [31:0]           MDR_wdata,
  input  logic                  mem_read,
  input  logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [31:0]           ram_wdata,
  output logic                  ram_re,
  output logic                  ram_we,
  input  logic [31:0]           ram_rdata,
  input  logic                  ram_ack,
  output logic [31:0]           mem_rdata,
  output logic                  mem_ready,
  output logic                  mem_busy,
  output logic                  mem_error
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_WAIT = 3'd1,
    WR_WAIT = 3'd2,
    DONE    = 3'd3
`ifdef MEM_IF_TIMEOUT_EN
    ,ERR    = 3'd4
`endif
  } state_t;

  // Legal timeout range is 1..15 (4-bit counter); an illegal value is visible
  // in the elaborated hierarchy as this named block.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 15) begin : g_timeout_cycles_out_of_range
  end

  state_t                r_state;
  state_t                w_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_wdata;
  logic [31:0]           r_rdata;
  logic                  w_latch_addr;
  logic                  w_latch_wdata;
  logic                  w_capture;
  logic                  w_expire;

`ifdef MEM_IF_TIMEOUT_EN
  localparam logic [3:0] LP_LAST_WAIT = 4'(TIMEOUT_CYCLES - 1);
  logic [3:0] r_cnt;
  logic       r_err;

  // r_cnt holds (wait cycle index - 1); it restarts whenever we are not waiting.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      r_cnt <= 4'd0;
    end else if (r_state == RD_WAIT || r_state == WR_WAIT) begin
      r_cnt <= r_cnt + 4'd1;
    end else begin
      r_cnt <= 4'd0;
    end
  end

  assign w_expire  = (r_cnt == LP_LAST_WAIT);
  assign mem_error = r_err;
`else
  assign w_expire  = 1'b0;
  assign mem_error = 1'b0;
`endif

  // Next state and strobes, all decoded from the registered state.
  always_comb begin
    w_next        = r_state;
    w_latch_addr  = 1'b0;
    w_latch_wdata = 1'b0;
    w_capture     = 1'b0;
    ram_re        = 1'b0;
    ram_we        = 1'b0;
    mem_ready     = 1'b0;
    mem_busy      = 1'b0;
    case (r_state)
      IDLE: begin
        // Write wins over a simultaneous read.
        if (mem_write) begin
          w_next        = WR_WAIT;
          w_latch_addr  = 1'b1;
          w_latch_wdata = 1'b1;
        end else if (mem_read) begin
          w_next       = RD_WAIT;
          w_latch_addr = 1'b1;
        end
      end
      RD_WAIT: begin
        ram_re   = 1'b1;
        mem_busy = 1'b1;
        // An ack on the expiry cycle still completes normally.
        if (ram_ack) begin
          w_next    = DONE;
          w_capture = 1'b1;
        end
`ifdef MEM_IF_TIMEOUT_EN
        else if (w_expire) begin
          w_next = ERR;
        end
`endif
      end
      WR_WAIT: begin
        ram_we   = 1'b1;
        mem_busy = 1'b1;
        if (ram_ack) begin
          w_next = DONE;
        end
`ifdef MEM_IF_TIMEOUT_EN
        else if (w_expire) begin
          w_next = ERR;
        end
`endif
      end
      DONE: begin
        mem_ready = 1'b1;
        mem_busy  = 1'b1;
        w_next    = IDLE;
      end
`ifdef MEM_IF_TIMEOUT_EN
      ERR: begin
        mem_ready = 1'b1;
        w_next    = IDLE;
      end
`endif
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
`ifdef MEM_IF_TIMEOUT_EN
      r_err   <= 1'b0;
`endif
    end else begin
      r_state <= w_next;
      if (w_latch_addr)  r_addr  <= MAR_addr;
      if (w_latch_wdata) r_wdata <= MDR_wdata;
      if (w_capture)     r_rdata <= ram_rdata;
`ifdef MEM_IF_TIMEOUT_EN
      // Sticky until reset.
      if (w_next == ERR) r_err <= 1'b1;
`endif
    end
  end

  assign ram_addr  = r_addr;
  assign ram_wdata = r_wdata;
  assign mem_rdata = r_rdata;

endmodule

// File: tb/tb_memory_interface_unit.sv
module tb_memory_interface_unit;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [8:0]  MAR_addr;
  logic [31:0] MDR_wdata;
  logic        mem_read;
  logic        mem_write;
  logic [8:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic        ram_re;
  logic        ram_we;
  logic [31:0] ram_rdata;
  logic        ram_ack;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        mem_busy;
  logic        mem_error;

  int n_checks = 0;
  int n_fail   = 0;

  memory_interface_unit #(.ADDR_WIDTH(9), .TIMEOUT_CYCLES(15)) dut (
    .Clock(Clock), .Reset(Reset), .MAR_addr(MAR_addr), .MDR_wdata(MDR_wdata),
    .mem_read(mem_read), .mem_write(mem_write), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_re(ram_re), .ram_we(ram_we),
    .ram_rdata(ram_rdata), .ram_ack(ram_ack), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .mem_busy(mem_busy), .mem_error(mem_error)
  );

  always #5 Clock = ~Clock;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One transaction. dly = wait cycle in which ram_ack is given (0 = never).
  // lat counts cycles with the request cycle as cycle 1; 0 means no mem_ready seen.
  task automatic txn(input logic rd, input logic wr, input logic [8:0] a,
                     input logic [31:0] wd, input logic [31:0] rdd, input int dly,
                     input bit noise, output int lat, output int nre, output int nwe,
                     output bit ok);
    mem_read = rd; mem_write = wr; MAR_addr = a; MDR_wdata = wd;
    tick();
    mem_read = 1'b0; mem_write = 1'b0;
    MAR_addr = 9'($urandom); MDR_wdata = $urandom;
    lat = 0; nre = 0; nwe = 0; ok = 1'b1;
    for (int c = 1; c <= 80; c++) begin
      if (mem_ready) begin
        lat = c + 1;
        break;
      end
      nre += int'(ram_re);
      nwe += int'(ram_we);
      if (ram_addr !== a || mem_busy !== 1'b1) ok = 1'b0;
      if (wr && ram_wdata !== wd) ok = 1'b0;
      ram_ack   = (c == dly);
      ram_rdata = (c == dly) ? rdd : $urandom;
      if (noise) begin
        mem_read  = 1'($urandom);
        mem_write = 1'($urandom);
        MAR_addr  = 9'($urandom);
      end
      tick();
    end
    ram_ack = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    tick();
    if (mem_ready !== 1'b0 || mem_busy !== 1'b0) ok = 1'b0;
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [8:0]  a;
    logic [31:0] wd;
    logic [31:0] rdd;
    int          dly;
    int          e_lat;
    int          e_re;
    int          e_we;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t        tbl[5];
  logic [31:0] model_rdata;
  int          lat, nre, nwe;
  bit          ok;

  initial begin
    tbl[0] = '{1'b1, 1'b0, 9'h05A, 32'h0,        32'hDEADBEEF, 1, 3, 1, 0, 32'hDEADBEEF};
    tbl[1] = '{1'b0, 1'b1, 9'h1FF, 32'h12345678, 32'hCAFEF00D, 4, 6, 0, 4, 32'hDEADBEEF};
    tbl[2] = '{1'b1, 1'b1, 9'h010, 32'hA5A5A5A5, 32'h11111111, 2, 4, 0, 2, 32'hDEADBEEF};
    tbl[3] = '{1'b1, 1'b0, 9'h0AB, 32'h0,        32'h0BADF00D, 3, 5, 3, 0, 32'h0BADF00D};
    tbl[4] = '{1'b1, 1'b0, 9'h000, 32'h0,        32'hFFFFFFFF, 2, 4, 2, 0, 32'hFFFFFFFF};

    Reset = 1'b0; MAR_addr = 9'h0; MDR_wdata = 32'h0; mem_read = 1'b0;
    mem_write = 1'b0; ram_rdata = 32'h0; ram_ack = 1'b0;
    tick(); tick();
    chk("reset ram_re", 32'(ram_re), 32'd0);
    chk("reset ram_we", 32'(ram_we), 32'd0);
    chk("reset mem_ready", 32'(mem_ready), 32'd0);
    chk("reset mem_busy", 32'(mem_busy), 32'd0);
    chk("reset mem_error", 32'(mem_error), 32'd0);
    chk("reset mem_rdata", mem_rdata, 32'd0);
    chk("reset ram_addr", 32'(ram_addr), 32'd0);
    chk("reset ram_wdata", ram_wdata, 32'd0);
    Reset = 1'b1;
    tick();

    // Directed table
    for (int i = 0; i < 5; i++) begin
      txn(tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].wd, tbl[i].rdd, tbl[i].dly, 1'b0, lat, nre, nwe, ok);
      chk($sformatf("vec%0d latency", i), 32'(lat), 32'(tbl[i].e_lat));
      chk($sformatf("vec%0d re cycles", i), 32'(nre), 32'(tbl[i].e_re));
      chk($sformatf("vec%0d we cycles", i), 32'(nwe), 32'(tbl[i].e_we));
      chk($sformatf("vec%0d stable/single pulse", i), 32'(ok), 32'd1);
      chk($sformatf("vec%0d mem_rdata", i), mem_rdata, tbl[i].e_rdata);
    end
    model_rdata = 32'hFFFFFFFF;

    // Request held through DONE is ignored there, then accepted once back in IDLE.
    mem_read = 1'b1; MAR_addr = 9'h020;
    tick();
    mem_read = 1'b0; mem_write = 1'b1; MAR_addr = 9'h0C3; MDR_wdata = 32'h5555AAAA;
    ram_ack = 1'b1; ram_rdata = 32'h00000077;
    tick();
    ram_ack = 1'b0;
    chk("held req: ready in DONE", 32'(mem_ready), 32'd1);
    chk("held req: read data", mem_rdata, 32'h00000077);
    tick();
    chk("held req: ignored in DONE", 32'(ram_we), 32'd0);
    tick();
    chk("held req: accepted from IDLE", 32'(ram_we), 32'd1);
    chk("held req: addr", 32'(ram_addr), 32'h0C3);
    chk("held req: wdata", ram_wdata, 32'h5555AAAA);
    mem_write = 1'b0; ram_ack = 1'b1;
    tick();
    ram_ack = 1'b0;
    chk("held req: write done", 32'(mem_ready), 32'd1);
    tick();
    model_rdata = 32'h00000077;

    // Reset during the second RD_WAIT cycle, with ram_ack also high.
    mem_read = 1'b1; MAR_addr = 9'h044;
    tick();
    mem_read = 1'b0;
    tick();
    Reset = 1'b0; ram_ack = 1'b1; ram_rdata = 32'h99999999;
    tick();
    Reset = 1'b1; ram_ack = 1'b0;
    chk("mid reset ram_re", 32'(ram_re), 32'd0);
    chk("mid reset busy", 32'(mem_busy), 32'd0);
    chk("mid reset ready", 32'(mem_ready), 32'd0);
    chk("mid reset mem_rdata", mem_rdata, 32'd0);
    chk("mid reset ram_addr", 32'(ram_addr), 32'd0);
    tick();
    chk("mid reset no late ready", 32'(mem_ready), 32'd0);
    model_rdata = 32'h0;

    // Randomized transactions against a simple model; noise on requests while busy.
    for (int i = 0; i < 40; i++) begin
      int          kind, dly, e_re, e_we;
      logic        rd, wr;
      logic [8:0]  a;
      logic [31:0] wd, rdd;
      kind = int'($urandom_range(0, 2));
      rd   = (kind != 1);
      wr   = (kind != 0);
      dly  = int'($urandom_range(1, 6));
      a    = 9'($urandom);
      wd   = $urandom;
      rdd  = $urandom;
      e_re = (rd && !wr) ? dly : 0;
      e_we = wr ? dly : 0;
      if (rd && !wr) model_rdata = rdd;
      txn(rd, wr, a, wd, rdd, dly, 1'b1, lat, nre, nwe, ok);
      chk("rand latency", 32'(lat), 32'(dly + 2));
      chk("rand re cycles", 32'(nre), 32'(e_re));
      chk("rand we cycles", 32'(nwe), 32'(e_we));
      chk("rand stable/single pulse", 32'(ok), 32'd1);
      chk("rand mem_rdata", mem_rdata, model_rdata);
    end

`ifdef MEM_IF_TIMEOUT_EN
    // No ack: ERR after 15 wait cycles, data untouched, sticky error.
    txn(1'b1, 1'b0, 9'h033, 32'h0, 32'h0, 0, 1'b0, lat, nre, nwe, ok);
    chk("timeout latency", 32'(lat), 32'd17);
    chk("timeout re cycles", 32'(nre), 32'd15);
    chk("timeout mem_rdata kept", mem_rdata, model_rdata);
    chk("timeout mem_error", 32'(mem_error), 32'd1);
    txn(1'b1, 1'b0, 9'h034, 32'h0, 32'h13572468, 1, 1'b0, lat, nre, nwe, ok);
    chk("error sticky", 32'(mem_error), 32'd1);
    Reset = 1'b0;
    tick();
    Reset = 1'b1;
    chk("error cleared by reset", 32'(mem_error), 32'd0);
    tick();
    txn(1'b1, 1'b0, 9'h035, 32'h0, 32'h2468ACE0, 15, 1'b0, lat, nre, nwe, ok);
    chk("ack at expiry latency", 32'(lat), 32'd17);
    chk("ack at expiry rdata", mem_rdata, 32'h2468ACE0);
    chk("ack at expiry no error", 32'(mem_error), 32'd0);
`else
    // Without the timeout the unit waits as long as it takes.
    txn(1'b1, 1'b0, 9'h033, 32'h0, 32'h2468ACE0, 30, 1'b0, lat, nre, nwe, ok);
    chk("long wait latency", 32'(lat), 32'd32);
    chk("long wait re cycles", 32'(nre), 32'd30);
    chk("long wait rdata", mem_rdata, 32'h2468ACE0);
    chk("long wait no error", 32'(mem_error), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/memory_interface_unit.md
MEMORY_INTERFACE_UNIT -- requirements
Module: memory_interface_unit

Interface
REQ-001 SHALL provide parameter ADDR_WIDTH, default 9, word address width (512 x 32-bit RAM).
REQ-002 SHALL provide parameter TIMEOUT_CYCLES, default 15, maximum wait for ram_ack, range 1..15.
REQ-003 SHALL use one clock with synchronous, active-low reset; ports are listed in REQ-004..REQ-017.
REQ-004 Clock  in  1  rising-edge clock.
REQ-005 Reset  in  1  synchronous active-low reset.
REQ-006 MAR_addr  in  ADDR_WIDTH  word address from MAR.
REQ-007 MDR_wdata  in  32  store data from MDR.
REQ-008 mem_read  in  1  read request; level, sampled in IDLE only.
REQ-009 mem_write  in  1  write request; level, sampled in IDLE only.
REQ-010 ram_addr  out  ADDR_WIDTH  registered RAM address.
REQ-011 ram_wdata  out  32  registered RAM write data.
REQ-012 ram_re / ram_we  out  1 each  RAM strobes.
REQ-013 ram_rdata  in  32  RAM read data, valid when ram_ack=1.
REQ-014 ram_ack  in  1  RAM completion.
REQ-015 mem_rdata  out  32  captured read data to the MDR input mux.
REQ-016 mem_ready  out  1  one-cycle completion pulse.
REQ-017 mem_busy / mem_error  out  1 each  transaction in flight / sticky timeout flag.

Function
REQ-018 FSM states SHALL be IDLE, RD_WAIT, WR_WAIT, DONE, ERR.
REQ-019 In IDLE with mem_write=1, SHALL latch MAR_addr and MDR_wdata into ram_addr/ram_wdata, go to WR_WAIT, and assert ram_we from the next cycle.
REQ-020 In IDLE with mem_read=1 and mem_write=0, SHALL latch MAR_addr, go to RD_WAIT, and assert ram_re from the next cycle.
REQ-021 Simultaneous mem_read and mem_write in IDLE SHALL be treated as a write; the read is dropped.
REQ-022 ram_re/ram_we SHALL stay high throughout RD_WAIT/WR_WAIT and drop on the cycle after ram_ack is sampled high.
REQ-023 In RD_WAIT, on ram_ack=1, SHALL load ram_rdata into mem_rdata on that edge and go to DONE.
REQ-024 In WR_WAIT, on ram_ack=1, SHALL go to DONE; mem_rdata is unchanged.
REQ-025 DONE SHALL last exactly one cycle with mem_ready=1, then return to IDLE.
REQ-026 Minimum latency SHALL be 3 cycles from request-sample edge to mem_ready, given ram_ack in the first wait cycle.
REQ-027 mem_busy SHALL be 1 in RD_WAIT, WR_WAIT and DONE, and 0 otherwise.
REQ-028 Requests arriving while not in IDLE SHALL be ignored; there is no queue.
REQ-029 ram_ack sampled high in IDLE, DONE or ERR SHALL be ignored.
REQ-030 mem_rdata SHALL hold its last value until the next completed read.
REQ-031 ram_addr and ram_wdata SHALL remain stable for the whole transaction.

Reset
REQ-032 Reset=0 on a rising edge SHALL force IDLE and clear ram_re, ram_we, mem_ready, mem_busy, mem_error, mem_rdata, ram_addr, ram_wdata and the timeout counter.
REQ-033 Reset mid-transaction SHALL abort it with no mem_ready pulse; strobes are low from the following cycle.
REQ-034 Reset SHALL take priority over all requests and over ram_ack in the same cycle.

Configuration
REQ-035 Macro MEM_IF_TIMEOUT_EN, when defined, SHALL enable a 4-bit wait counter in RD_WAIT/WR_WAIT.
REQ-036 With MEM_IF_TIMEOUT_EN defined, if ram_ack has not arrived after TIMEOUT_CYCLES wait cycles, SHALL go to ERR, drop strobes, and set mem_error.
REQ-037 ERR SHALL last one cycle with mem_ready=1 and mem_rdata unchanged, then return to IDLE; mem_error stays set until Reset.
REQ-038 With MEM_IF_TIMEOUT_EN defined, ram_ack on the same cycle the counter expires SHALL win and complete normally.
REQ-039 Without MEM_IF_TIMEOUT_EN, SHALL wait indefinitely for ram_ack, omit the counter and the ERR state, and tie mem_error to 0.

Verification
REQ-040 Read with ack in the first wait cycle: MAR_addr=0x05A, ram_rdata=0xDEADBEEF -> ram_re high for 1 cycle, mem_rdata=0xDEADBEEF, mem_ready pulses 3 cycles after the request edge.
REQ-041 Write with ack delayed 4 cycles: addr 0x1FF, data 0x12345678 -> ram_we high for 4 cycles, ram_addr/ram_wdata stable, a single mem_ready pulse.
REQ-042 mem_read=mem_write=1 at addr 0x010 -> only ram_we asserted; mem_rdata unchanged.
REQ-043 Reset=0 on the second RD_WAIT cycle -> IDLE next cycle, all outputs 0, no mem_ready pulse.
REQ-044 MEM_IF_TIMEOUT_EN defined, TIMEOUT_CYCLES=15, no ack -> ERR after 15 wait cycles, mem_error=1 held until Reset; ack exactly on cycle 15 -> normal completion, mem_error=0.
REQ-045 New request while mem_busy=1 -> ignored; the next accepted request is only one still asserted in IDLE.
